// File: rtl/nzcv_pkg.sv
// Shared types for the NZCV condition unit: condition codes, flag bit
// positions and the output-stage state encoding.
package nzcv_pkg;

  // Flag register bit positions, as presented on the ALU flag bus.
  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  // 4-bit branch condition codes.
  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  // One-entry output stage: EMPTY has no result, FULL holds one result.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/nzcv_cond_eval.sv
// Purely combinational condition evaluator: decides whether a 4-bit
// condition code holds for a given set of NZCV flags. NV is treated as
// always-true, the same as AL.
module cond_eval
  import nzcv_pkg::*;
(
  input  logic [3:0] nzcv,
  input  cond_e      cond,
  output logic       taken
);

  logic n_flag;
  logic z_flag;
  logic c_flag;
  logic v_flag;
  logic gt_term;
  logic hi_term;

  assign n_flag  = nzcv[N_BIT];
  assign z_flag  = nzcv[Z_BIT];
  assign c_flag  = nzcv[C_BIT];
  assign v_flag  = nzcv[V_BIT];
  assign hi_term = c_flag & ~z_flag;
  assign gt_term = ~z_flag & (n_flag == v_flag);

  // Decode the condition code into a single taken/not-taken outcome.
  always_comb begin
    taken = 1'b1;
    case (cond)
      COND_EQ: taken = z_flag;
      COND_NE: taken = ~z_flag;
      COND_CS: taken = c_flag;
      COND_CC: taken = ~c_flag;
      COND_MI: taken = n_flag;
      COND_PL: taken = ~n_flag;
      COND_VS: taken = v_flag;
      COND_VC: taken = ~v_flag;
      COND_HI: taken = hi_term;
      COND_LS: taken = ~hi_term;
      COND_GE: taken = (n_flag == v_flag);
      COND_LT: taken = (n_flag != v_flag);
      COND_GT: taken = gt_term;
      COND_LE: taken = ~gt_term;
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b1;
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/nzcv_cond_unit.sv
// NZCV flag register plus branch condition resolution with a one-entry
// registered output stage and valid/ready handshakes on both sides.
// Optional feature macro: NZCV_BYPASS_EN -- when defined, a request that
// coincides with a flag write is evaluated against the incoming flags in
// the same cycle; otherwise the request is stalled one cycle and evaluated
// against the registered flags.
module nzcv_cond_unit
  import nzcv_pkg::*;
#(
  parameter int         AW         = 64,
  parameter logic [3:0] RESET_NZCV = 4'b0000
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [3:0]    i_nzcv,
  input  logic          i_flags_we,
  input  logic          i_flags_pending,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [3:0]    i_cond,
  input  logic [AW-1:0] i_target,
  output logic          o_resp_valid,
  input  logic          i_resp_ready,
  output logic          o_taken,
  output logic [AW-1:0] o_target,
  output logic [3:0]    o_nzcv
);

  logic [3:0]    nzcv_q;
  logic [3:0]    eval_flags;
  logic          hazard;
  logic          accept;
  logic          drain;
  logic          eval_taken;
  out_state_e    state_q;
  logic          taken_q;
  logic [AW-1:0] target_q;

`ifdef NZCV_BYPASS_EN
  assign eval_flags = i_flags_we ? i_nzcv : nzcv_q;
  assign hazard     = 1'b0;
`else
  assign eval_flags = nzcv_q;
  assign hazard     = i_flags_we;
`endif

  assign o_req_ready  = ~i_flags_pending & ~hazard &
                        ((state_q == EMPTY) | i_resp_ready);
  assign accept       = i_req_valid & o_req_ready;
  assign drain        = (state_q == FULL) & i_resp_ready;
  assign o_resp_valid = (state_q == FULL);
  assign o_taken      = taken_q;
  assign o_target     = target_q;
  assign o_nzcv       = nzcv_q;

  cond_eval u_cond_eval (
    .nzcv  (eval_flags),
    .cond  (cond_e'(i_cond)),
    .taken (eval_taken)
  );

  // Architectural flag register, written only by flag-setting ALU ops.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      nzcv_q <= RESET_NZCV;
    end else if (i_flags_we) begin
      nzcv_q <= i_nzcv;
    end
  end

  // Output stage: an accept always (re)loads the result, which also covers
  // drain-and-refill on the same edge; a drain without accept empties it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= EMPTY;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q  <= FULL;
            taken_q  <= eval_taken;
            target_q <= i_target;
          end
        end
        FULL: begin
          if (accept) begin
            state_q  <= FULL;
            taken_q  <= eval_taken;
            target_q <= i_target;
          end else if (drain) begin
            state_q  <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_nzcv_cond_unit.sv
// Directed self-checking bench for nzcv_cond_unit. Works in both the
// default build and with NZCV_BYPASS_EN defined.
module tb_nzcv_cond_unit;

  localparam int AW = 64;

  logic          clk;
  logic          rst_n;
  logic [3:0]    nzcv_in;
  logic          flags_we;
  logic          flags_pending;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    cond;
  logic [AW-1:0] target_in;
  logic          resp_valid;
  logic          resp_ready;
  logic          taken;
  logic [AW-1:0] target_out;
  logic [3:0]    nzcv_out;

  int check_count = 0;
  int pass_count  = 0;

  nzcv_cond_unit #(
    .AW         (AW),
    .RESET_NZCV (4'b0100)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_nzcv          (nzcv_in),
    .i_flags_we      (flags_we),
    .i_flags_pending (flags_pending),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_cond          (cond),
    .i_target        (target_in),
    .o_resp_valid    (resp_valid),
    .i_resp_ready    (resp_ready),
    .o_taken         (taken),
    .o_target        (target_out),
    .o_nzcv          (nzcv_out)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic v, input logic [3:0] c,
                               input logic [AW-1:0] t);
    req_valid = v;
    cond      = c;
    target_in = t;
  endtask

  task automatic checkOutput(input string tag, input logic [AW-1:0] observed,
                             input logic [AW-1:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] seq_cond  [6];
  logic       seq_taken [6];

  // Directed sequence walking through the main behaviours of the unit.
  initial begin
    seq_cond  = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd4, 4'd7};
    seq_taken = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    rst_n         = 1'b0;
    nzcv_in       = 4'b0000;
    flags_we      = 1'b0;
    flags_pending = 1'b0;
    resp_ready    = 1'b0;
    applyStimulus(1'b0, 4'd0, '0);
    stepClk();
    stepClk();
    checkOutput("reset_valid", resp_valid, 1'b0);
    checkOutput("reset_taken", taken, 1'b0);
    checkOutput("reset_target", target_out, '0);
    checkOutput("reset_nzcv", nzcv_out, 4'b0100);

    // EQ with reset flags Z=1
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    applyStimulus(1'b1, 4'd0, 64'h100);
    #1;
    checkOutput("eq_ready", req_ready, 1'b1);
    stepClk();
    applyStimulus(1'b0, 4'd0, '0);
    checkOutput("eq_valid", resp_valid, 1'b1);
    checkOutput("eq_taken", taken, 1'b1);
    checkOutput("eq_target", target_out, 64'h100);
    stepClk();
    checkOutput("eq_drained", resp_valid, 1'b0);

    // Flags N,V then back-to-back signed comparisons
    flags_we = 1'b1;
    nzcv_in  = 4'b1001;
    stepClk();
    flags_we = 1'b0;
    checkOutput("nzcv_1001", nzcv_out, 4'b1001);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, seq_cond[i], 64'h200 + 64'(i));
      #1;
      checkOutput("b2b_ready", req_ready, 1'b1);
      stepClk();
      checkOutput("b2b_valid", resp_valid, 1'b1);
      checkOutput("b2b_taken", taken, seq_taken[i]);
      checkOutput("b2b_target", target_out, 64'h200 + 64'(i));
    end
    applyStimulus(1'b0, 4'd0, '0);
    stepClk();
    checkOutput("b2b_drained", resp_valid, 1'b0);

    // Flag write coinciding with a HI request
    flags_we = 1'b1;
    nzcv_in  = 4'b0010;
    applyStimulus(1'b1, 4'd8, 64'h300);
    #1;
`ifdef NZCV_BYPASS_EN
    checkOutput("hi_ready_same", req_ready, 1'b1);
    stepClk();
    flags_we = 1'b0;
    applyStimulus(1'b0, 4'd0, '0);
`else
    checkOutput("hi_ready_stall", req_ready, 1'b0);
    stepClk();
    flags_we = 1'b0;
    checkOutput("hi_no_resp", resp_valid, 1'b0);
    #1;
    checkOutput("hi_ready_next", req_ready, 1'b1);
    stepClk();
    applyStimulus(1'b0, 4'd0, '0);
`endif
    checkOutput("hi_valid", resp_valid, 1'b1);
    checkOutput("hi_taken", taken, 1'b1);
    checkOutput("hi_target", target_out, 64'h300);
    checkOutput("nzcv_0010", nzcv_out, 4'b0010);
    stepClk();
    checkOutput("hi_drained", resp_valid, 1'b0);

    // Flags pending blocks acceptance for three cycles
    flags_pending = 1'b1;
    applyStimulus(1'b1, 4'd0, 64'h400);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("pend_ready", req_ready, 1'b0);
      stepClk();
      checkOutput("pend_no_resp", resp_valid, 1'b0);
    end
    flags_pending = 1'b0;
    #1;
    checkOutput("pend_release_ready", req_ready, 1'b1);
    stepClk();
    applyStimulus(1'b0, 4'd0, '0);
    checkOutput("pend_valid", resp_valid, 1'b1);
    checkOutput("pend_taken", taken, 1'b0);
    checkOutput("pend_target", target_out, 64'h400);

    // Backpressure while FULL, then drain and refill on the same edge
    resp_ready = 1'b0;
    applyStimulus(1'b1, 4'd2, 64'h500);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("bp_ready", req_ready, 1'b0);
      stepClk();
      checkOutput("bp_valid", resp_valid, 1'b1);
      checkOutput("bp_taken", taken, 1'b0);
      checkOutput("bp_target", target_out, 64'h400);
    end
    resp_ready = 1'b1;
    #1;
    checkOutput("refill_ready", req_ready, 1'b1);
    stepClk();
    applyStimulus(1'b0, 4'd0, '0);
    resp_ready = 1'b0;
    checkOutput("refill_valid", resp_valid, 1'b1);
    checkOutput("refill_taken", taken, 1'b1);
    checkOutput("refill_target", target_out, 64'h500);

    // Reset while FULL discards the held result and restores flags
    rst_n = 1'b0;
    stepClk();
    checkOutput("rst_full_valid", resp_valid, 1'b0);
    checkOutput("rst_full_taken", taken, 1'b0);
    checkOutput("rst_full_target", target_out, '0);
    checkOutput("rst_full_nzcv", nzcv_out, 4'b0100);
    rst_n = 1'b1;
    stepClk();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
